// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream, writes
// big-endian 32-bit words and holds the CPU in reset until a good checksum.
module instr_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              chk_err
);

    localparam int unsigned TOT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_COLLECT,
        S_WRITE,
        S_CHK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TOT_W-1:0]    total_q, total_d;
    logic [7:0]          xor_q, xor_d;
    logic [23:0]         asm_q, asm_d;
    logic                byte_ready_d, wr_en_d, cpu_hold_d, busy_d, done_d, chk_err_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [31:0]         wr_data_d;
    logic                xfer;
    logic                hdr_clip;
    logic                last_word;

    assign xfer      = byte_valid && byte_ready;
    // Header 0 or anything beyond the memory size loads the whole memory
    assign hdr_clip  = (byte_in == 8'd0) || (32'(byte_in) > DEPTH);
    assign last_word = ({1'b0, addr_q} == (total_q - TOT_W'(1)));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            total_q    <= '0;
            xor_q      <= '0;
            asm_q      <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            chk_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            total_q    <= total_d;
            xor_q      <= xor_d;
            asm_q      <= asm_d;
            byte_ready <= byte_ready_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            cpu_hold   <= cpu_hold_d;
            busy       <= busy_d;
            done       <= done_d;
            chk_err    <= chk_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        total_d    = total_q;
        xor_d      = xor_q;
        asm_d      = asm_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        cpu_hold_d = cpu_hold;
        busy_d     = busy;
        done_d     = done;
        chk_err_d  = chk_err;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_HDR;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    chk_err_d  = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    total_d = hdr_clip ? TOT_W'(DEPTH) : TOT_W'(byte_in);
                    addr_d  = '0;
                    cnt_d   = '0;
                    xor_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (xfer) begin
                    asm_d = {asm_q[15:0], byte_in};
                    xor_d = xor_q ^ byte_in;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d   = S_WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {asm_q, byte_in};
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d = S_CHK;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_COLLECT;
                end
            end
            S_CHK: begin
                if (xfer) begin
                    chk_err_d  = (byte_in != xor_q);
                    cpu_hold_d = (byte_in != xor_q);
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready follows the state being entered, so it never depends on byte_valid
        byte_ready_d = (state_d == S_HDR) || (state_d == S_COLLECT) || (state_d == S_CHK);
    end

endmodule
